// File: rtl/serial_add_sub_unit.sv
// Bit-serial WIDTH-bit adder/subtractor: one full-adder slice (two half adders + OR)
// fed by operand shift registers and a carry flop. Define OVF_FLAG_EN to add overflow_o.

module half_adder (
   input  logic i_a,
   input  logic i_b,
   output logic o_s,
   output logic o_c
);
   assign o_s = i_a ^ i_b;
   assign o_c = i_a & i_b;
endmodule

module serial_add_sub_unit #(
   parameter int WIDTH = 4
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             start_i,
   output logic             ready_o,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             sub_i,
   output logic [WIDTH-1:0] sum_o,
   output logic             carry_o,
   output logic             valid_o,
   input  logic             result_ready_i
`ifdef OVF_FLAG_EN
   ,
   output logic             overflow_o
`endif
);
   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

   state_t           r_state;
   state_t           w_state_next;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-2:0] r_res;
   logic [WIDTH-1:0] r_sum;
   logic             r_c;
   logic             r_carry;
   logic [CW-1:0]    r_cnt;

   logic             w_accept;
   logic             w_last;
   logic             w_s1;
   logic             w_c1;
   logic             w_s;
   logic             w_c2;
   logic             w_cout;
   logic [WIDTH-1:0] w_res_next;

   half_adder u_ha0 (.i_a(r_a[0]), .i_b(r_b[0]), .o_s(w_s1), .o_c(w_c1));
   half_adder u_ha1 (.i_a(w_s1),   .i_b(r_c),    .o_s(w_s),  .o_c(w_c2));

   assign w_cout     = w_c1 | w_c2;
   assign w_last     = (r_cnt == CW'(WIDTH - 1));
   assign w_res_next = {w_s, r_res};
   assign w_accept   = start_i & ready_o;

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) r_state <= S_IDLE;
      else          r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (start_i) w_state_next = S_SHIFT;
         S_SHIFT: if (w_last) w_state_next = S_DONE;
         S_DONE:  if (result_ready_i) w_state_next = start_i ? S_SHIFT : S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   always_comb begin
      ready_o = (r_state == S_IDLE) | ((r_state == S_DONE) & result_ready_i);
      valid_o = (r_state == S_DONE);
   end

`ifdef OVF_FLAG_EN
   logic r_ovf;
   assign overflow_o = r_ovf;
`endif

   // Result bits collect in r_res; the visible outputs update only on the final bit.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         r_a     <= '0;
         r_b     <= '0;
         r_c     <= 1'b0;
         r_cnt   <= '0;
         r_res   <= '0;
         r_sum   <= '0;
         r_carry <= 1'b0;
`ifdef OVF_FLAG_EN
         r_ovf   <= 1'b0;
`endif
      end else if (w_accept) begin
         r_a   <= a_i;
         r_b   <= b_i ^ {WIDTH{sub_i}};
         r_c   <= sub_i;
         r_cnt <= '0;
      end else if (r_state == S_SHIFT) begin
         r_a   <= r_a >> 1;
         r_b   <= r_b >> 1;
         r_c   <= w_cout;
         r_res <= w_res_next[WIDTH-1:1];
         r_cnt <= r_cnt + CW'(1);
         if (w_last) begin
            r_sum   <= w_res_next;
            r_carry <= w_cout;
`ifdef OVF_FLAG_EN
            r_ovf   <= r_c ^ w_cout;
`endif
         end
      end
   end

   assign sum_o   = r_sum;
   assign carry_o = r_carry;

endmodule

// File: tb/tb_serial_add_sub_unit.sv
// Directed and exhaustive checks of serial_add_sub_unit at WIDTH=4.
// Overflow checks are included when OVF_FLAG_EN is defined.

module tb_serial_add_sub_unit;
   localparam int WIDTH = 4;

   logic             clk_i = 1'b0;
   logic             rst_n_i;
   logic             start_i;
   logic             ready_o;
   logic [WIDTH-1:0] a_i;
   logic [WIDTH-1:0] b_i;
   logic             sub_i;
   logic [WIDTH-1:0] sum_o;
   logic             carry_o;
   logic             valid_o;
   logic             result_ready_i;
`ifdef OVF_FLAG_EN
   logic             overflow_o;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   serial_add_sub_unit #(.WIDTH(WIDTH)) dut (
      .clk_i          (clk_i),
      .rst_n_i        (rst_n_i),
      .start_i        (start_i),
      .ready_o        (ready_o),
      .a_i            (a_i),
      .b_i            (b_i),
      .sub_i          (sub_i),
      .sum_o          (sum_o),
      .carry_o        (carry_o),
      .valid_o        (valid_o),
      .result_ready_i (result_ready_i)
`ifdef OVF_FLAG_EN
      ,
      .overflow_o     (overflow_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
   endtask

   task automatic tick;
      @(posedge clk_i);
      #1;
   endtask

   // Reference: {ovf, carry, sum} from plain integer arithmetic.
   function automatic logic [5:0] model(input logic [3:0] a, input logic [3:0] b, input logic s);
      logic [4:0] t;
      int sa, sb, r;
      logic ovf;
      t  = s ? (5'd16 + {1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
      sa = (a > 7) ? int'(a) - 16 : int'(a);
      sb = (b > 7) ? int'(b) - 16 : int'(b);
      r  = s ? sa - sb : sa + sb;
      ovf = (r > 7) || (r < -8);
      return {ovf, t};
   endfunction

   task automatic wait_valid(input string tag, input int exp_lat);
      int lat;
      lat = 0;
      while (!valid_o && lat < 20) begin
         tick;
         lat++;
      end
      check($sformatf("%s.latency", tag), lat, exp_lat);
   endtask

   task automatic check_result(input string tag, input logic [3:0] es, input logic ec, input logic eo);
      check($sformatf("%s.sum", tag), sum_o, es);
      check($sformatf("%s.carry", tag), carry_o, ec);
`ifdef OVF_FLAG_EN
      check($sformatf("%s.ovf", tag), overflow_o, eo);
`endif
      $display("op %s: sum=%0h carry=%0b (exp sum=%0h carry=%0b ovf=%0b)", tag, sum_o, carry_o, es, ec, eo);
   endtask

   task automatic run_op(input string tag, input logic [3:0] a, input logic [3:0] b, input logic s,
                         input logic [3:0] es, input logic ec, input logic eo);
      check($sformatf("%s.ready", tag), ready_o, 1);
      a_i = a; b_i = b; sub_i = s; start_i = 1'b1;
      tick;
      start_i = 1'b0;
      a_i = ~a; b_i = ~b; sub_i = ~s;
      wait_valid(tag, WIDTH);
      check_result(tag, es, ec, eo);
      result_ready_i = 1'b1;
      tick;
      result_ready_i = 1'b0;
      check($sformatf("%s.consumed", tag), valid_o, 0);
   endtask

   initial begin
      logic [5:0] m;
      rst_n_i = 1'b0; start_i = 1'b0; a_i = '0; b_i = '0; sub_i = 1'b0; result_ready_i = 1'b0;
      repeat (3) tick;
      check("rst.valid", valid_o, 0);
      check("rst.sum", sum_o, 0);
      check("rst.carry", carry_o, 0);
      check("rst.ready", ready_o, 1);
`ifdef OVF_FLAG_EN
      check("rst.ovf", overflow_o, 0);
`endif
      rst_n_i = 1'b1;
      tick;

      run_op("add5p3", 4'd5, 4'd3, 1'b0, 4'h8, 1'b0, 1'b1);
      run_op("add9p9", 4'd9, 4'd9, 1'b0, 4'h2, 1'b1, 1'b1);
      run_op("sub3m5", 4'd3, 4'd5, 1'b1, 4'hE, 1'b0, 1'b0);
      run_op("sub5m3", 4'd5, 4'd3, 1'b1, 4'h2, 1'b1, 1'b0);

      // Busy: start during SHIFT is ignored, then hold the result, then back-to-back.
      a_i = 4'd6; b_i = 4'd1; sub_i = 1'b0; start_i = 1'b1;
      tick;
      start_i = 1'b0;
      tick;
      a_i = 4'hF; b_i = 4'hF; sub_i = 1'b1; start_i = 1'b1;
      #1;
      check("busy.ready", ready_o, 0);
      tick;
      start_i = 1'b0;
      wait_valid("busy", 2);
      check_result("busy", 4'h7, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick;
         check($sformatf("hold%0d.valid", i), valid_o, 1);
         check($sformatf("hold%0d.sum", i), sum_o, 4'h7);
      end
      a_i = 4'd2; b_i = 4'd3; sub_i = 1'b1; start_i = 1'b1; result_ready_i = 1'b1;
      #1;
      check("b2b.ready", ready_o, 1);
      tick;
      start_i = 1'b0; result_ready_i = 1'b0; a_i = 4'd0; b_i = 4'd0; sub_i = 1'b0;
      check("b2b.valid_drop", valid_o, 0);
      check("b2b.sum_held", sum_o, 4'h7);
      wait_valid("b2b", WIDTH);
      check_result("b2b", 4'hF, 1'b0, 1'b0);
      result_ready_i = 1'b1;
      tick;
      result_ready_i = 1'b0;

      // Reset in the second SHIFT cycle aborts the operation.
      a_i = 4'd3; b_i = 4'd4; sub_i = 1'b0; start_i = 1'b1;
      tick;
      start_i = 1'b0;
      tick;
      rst_n_i = 1'b0;
      tick;
      check("abort.valid", valid_o, 0);
      check("abort.sum", sum_o, 0);
      check("abort.carry", carry_o, 0);
      check("abort.ready", ready_o, 1);
      rst_n_i = 1'b1;
      tick;
      check("abort.still_idle", valid_o, 0);
      run_op("add7p1", 4'd7, 4'd1, 1'b0, 4'h8, 1'b0, 1'b1);

      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            for (int s = 0; s < 2; s++) begin
               m = model(4'(a), 4'(b), 1'(s));
               run_op($sformatf("sweep_%0h_%0h_%0d", a, b, s), 4'(a), 4'(b), 1'(s), m[3:0], m[4], m[5]);
            end
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
